// File: rtl/conv_window_gen_pkg.sv
// Shared definitions for the window generator and the convolution engine it feeds.
// Pure constants and types; no logic, no latency.
// Not applicable: nothing here carries flow control.
package conv_window_gen_pkg;

    // Pixel width shared with the convolution engine's pixel1..pixel9 inputs.
    localparam int PIX_W = 4;

    // Default frame geometry.
    localparam int DEF_IMG_WIDTH  = 28;
    localparam int DEF_IMG_HEIGHT = 28;

    typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel stream in, 3x3 window out, bundled between a producer and the window generator.
// Wires only; no latency.
// No backpressure: pix_valid is a pure accept strobe and windows are never stalled downstream.
interface conv_window_gen_if
    import conv_window_gen_pkg::*;
#(
    parameter int PIX_W = conv_window_gen_pkg::PIX_W
);

    // Raster-order pixel stream
    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_sof;

    // 3x3 window taps, row-major; pixel9 is the newest pixel
    logic [PIX_W-1:0] pixel1;
    logic [PIX_W-1:0] pixel2;
    logic [PIX_W-1:0] pixel3;
    logic [PIX_W-1:0] pixel4;
    logic [PIX_W-1:0] pixel5;
    logic [PIX_W-1:0] pixel6;
    logic [PIX_W-1:0] pixel7;
    logic [PIX_W-1:0] pixel8;
    logic [PIX_W-1:0] pixel9;
    logic             win_valid;
    logic             frame_done;

    // Pixel source side: drives the stream, observes windows.
    modport master (
        output pix_in, pix_valid, pix_sof,
        input  pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8, pixel9,
        input  win_valid, frame_done
    );

    // Window generator side: consumes the stream, produces windows.
    modport slave (
        input  pix_in, pix_valid, pix_sof,
        output pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8, pixel9,
        output win_valid, frame_done
    );

endinterface

// File: rtl/conv_line_buffer.sv
// Single-port DEPTH x PIX_W line store with read-before-write on the same address.
// Read is combinational (old contents visible in the write cycle); write lands on the clock edge.
// No backpressure; the caller's write enable is the only qualifier. Contents are never reset.
module conv_line_buffer #(
    parameter int DEPTH = 28,
    parameter int PIX_W = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    // The old word is read out before this cycle's write replaces it.
    assign rdata = mem[addr];

    // Write the new word at the clock edge; no reset, validity is tracked upstream.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3 "valid"-only sliding windows for the convolution engine.
// Latency 1 cycle from accepting pixel (r,c) to the window with (r,c) at pixel9.
// No backpressure: every pix_valid cycle is accepted; idle cycles freeze taps and drop win_valid.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int PIX_W      = conv_window_gen_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    conv_window_gen_if.slave win
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    // Position of the next pixel to be accepted
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Position of the pixel on the input this cycle (pix_sof pulls it to the origin)
    logic [COL_W-1:0] col_cur;
    logic [ROW_W-1:0] row_cur;
    logic [COL_W-1:0] col_next;
    logic [ROW_W-1:0] row_next;

    logic             accept;
    logic             buf_we;
    logic [PIX_W-1:0] line_a_rd;   // line r-1 at this column
    logic [PIX_W-1:0] line_b_rd;   // line r-2 at this column

    // Window taps, row-major: [0..2] oldest line, [6..8] current line
    logic [PIX_W-1:0] tap [9];
    logic             win_valid_q;
    logic             frame_done_q;

    // Resolve the current pixel position and where the counters go after it.
    always_comb begin
        accept   = win.pix_valid;
        col_cur  = col;
        row_cur  = row;
        col_next = col;
        row_next = row;
        if (win.pix_sof) begin
            col_cur = '0;
            row_cur = '0;
        end
        if (col_cur == COL_LAST) begin
            col_next = '0;
            row_next = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
        end else begin
            col_next = col_cur + 1'b1;
            row_next = row_cur;
        end
    end

    // Holding writes off during reset keeps the buffers quiet; their contents are don't-care anyway.
    assign buf_we = accept && !rst;

    // Buffer A: previous line. Receives the incoming pixel.
    conv_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .PIX_W (PIX_W)
    ) u_line_a (
        .clk   (clk),
        .we    (buf_we),
        .addr  (col_cur),
        .wdata (win.pix_in),
        .rdata (line_a_rd)
    );

    // Buffer B: line before that. Receives what A held at this column.
    conv_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .PIX_W (PIX_W)
    ) u_line_b (
        .clk   (clk),
        .we    (buf_we),
        .addr  (col_cur),
        .wdata (line_a_rd),
        .rdata (line_b_rd)
    );

    // Advance counters and shift the window on each accept; flags are recomputed every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            col          <= '0;
            row          <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                tap[i] <= '0;
            end
        end else begin
            // Columns 0 and 1 straddle a line boundary, rows 0 and 1 lack history: never valid.
            win_valid_q  <= accept && (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);
            frame_done_q <= accept && (row_cur == ROW_LAST) && (col_cur == COL_LAST);
            if (accept) begin
                col    <= col_next;
                row    <= row_next;
                tap[0] <= tap[1];
                tap[1] <= tap[2];
                tap[2] <= line_b_rd;
                tap[3] <= tap[4];
                tap[4] <= tap[5];
                tap[5] <= line_a_rd;
                tap[6] <= tap[7];
                tap[7] <= tap[8];
                tap[8] <= win.pix_in;
            end
        end
    end

    assign win.pixel1     = tap[0];
    assign win.pixel2     = tap[1];
    assign win.pixel3     = tap[2];
    assign win.pixel4     = tap[3];
    assign win.pixel5     = tap[4];
    assign win.pixel6     = tap[5];
    assign win.pixel7     = tap[6];
    assign win.pixel8     = tap[7];
    assign win.pixel9     = tap[8];
    assign win.win_valid  = win_valid_q;
    assign win.frame_done = frame_done_q;

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Converts a raster-order pixel stream (one pixel per accepted cycle) into 3x3 sliding windows.
- Presents each window as nine parallel 4-bit pixels, the form the convolution engine consumes on its pixel1..pixel9 inputs.
- Sits upstream of the convolution engine as the producer end of its window interface.
- Uses "valid" (no padding) windows only: an IMG_WIDTH x IMG_HEIGHT frame yields (IMG_WIDTH-2) x (IMG_HEIGHT-2) windows.

Parameters:
- IMG_WIDTH, 28, pixels per line; legal range 3..1024.
- IMG_HEIGHT, 28, lines per frame; legal range 3..1024.
- PIX_W, 4, pixel bit width; must match the convolution pixel width.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pix_in  input  PIX_W  incoming pixel, raster order (row-major, left to right).
- pix_valid  input  1  pix_in is accepted this cycle; no backpressure.
- pix_sof  input  1  start of frame; qualified by pix_valid; marks this pixel as (row 0, col 0).
- pixel1..pixel9  output  PIX_W each  window taps, row-major. pixel1 = (r-2,c-2), pixel3 = (r-2,c), pixel7 = (r,c-2), pixel9 = (r,c) = newest pixel.
- win_valid  output  1  pixel1..pixel9 hold a complete window this cycle.
- frame_done  output  1  one-cycle pulse; the last window of the frame is on the outputs.

Behaviour:
- Reset (rst=1 at a clock edge):
  - col, row, pixel1..pixel9, win_valid and frame_done all go to 0.
  - Line-buffer RAM contents are not cleared; output validity is gated by the counters only.
  - rst has priority over every other input.
- Storage:
  - Two line buffers, IMG_WIDTH deep, each PIX_W wide. Buffer A holds line r-1, buffer B holds line r-2.
  - Addressed by col; read-before-write in the same cycle.
  - On accept: B[col] <= A[col]; A[col] <= pix_in.
- Window shift register (on accept): each of the three tap rows shifts left by one.
  - New right column: pixel3 <= B[col], pixel6 <= A[col], pixel9 <= pix_in.
- Counters:
  - col: 0..IMG_WIDTH-1. row: 0..IMG_HEIGHT-1.
  - Both advance only on accept.
  - col wraps to 0 and increments row; row wraps to 0 after (H-1, W-1).
  - Counter width is $clog2 of the dimension.
- Start of frame: pix_valid=1 with pix_sof=1 forces this pixel to position (0,0).
  - The counters then continue from (0,1).
  - A partial previous frame is abandoned with no frame_done.
  - pix_sof with pix_valid=0 is ignored.
- Output timing:
  - Registered; latency is 1 cycle from accepting pixel (r,c) to the window with (r,c) at pixel9.
  - win_valid=1 in the cycle after an accept where row>=2 and col>=2. Otherwise win_valid=0.
  - Windows at col 0 and 1 straddle a line boundary and are never flagged valid.
- Stall: pix_valid=0 means no shift, no counter change and win_valid=0 next cycle. Tap outputs hold their last values.
- frame_done: asserts together with the win_valid generated by pixel (H-1, W-1).
- Back-to-back frames need no idle cycles. Row 0 of the next frame produces no windows, so stale buffer data is never exposed.
- Widths: no arithmetic on pixels; values pass through unchanged.
- Reset mid-frame: the next accepted pixel is treated as (0,0) whether or not pix_sof is set. Windows resume only at row 2, col 2.

Decomposition:
- Shared package holds PIX_W, the default IMG_WIDTH and IMG_HEIGHT, and a typedef pix_t (logic [PIX_W-1:0]).
  - The convolution engine's kernel and pixel widths come from the same package.
- One natural sub-module: conv_line_buffer. It is a single-port IMG_WIDTH x PIX_W read-before-write RAM with a write enable, instantiated twice.
- Counters, tap register and valid/done logic stay in the top level.

Test Plan:
- Basic 4x4 (IMG_WIDTH=IMG_HEIGHT=4): feed 16 pixels with values 0..15 continuously, pix_sof on the first.
  - Expect exactly 4 win_valid pulses.
  - First pulse is the cycle after pixel 10, with pixel1..9 = 0,1,2,4,5,6,8,9,10.
  - Last pulse is 5,6,7,9,10,11,13,14,15, with frame_done=1 on it.
- Stalls: same 4x4 frame with pix_valid low on every other cycle.
  - Same 4 windows with the same values.
  - win_valid never high in a cycle following a non-accept.
- Row boundary: 4x4, check the cycles after accepting pixels 12 and 13 (cols 0,1 of row 3). win_valid=0 for both.
- Reset mid-frame: 4x4, assert rst after 9 pixels, then send a full frame of 16..31 (mod 16) without pix_sof.
  - First window is 0,1,2,4,5,6,8,9,10 of the new data (values 16+k mod 16).
  - No window is ever built from pre-reset data.
- Default 28x28 with back-to-back frames and pix_sof each frame:
  - 676 win_valid pulses per frame.
  - One frame_done per frame.
  - No gap cycles between the frames.
- Integration with the convolution engine: all-ones image and kernel all ones. Every valid window yields sum=9, one cycle after win_valid.
